// File: rtl/csi2tx_comp_byte_packer_pkg.sv
// ----------------------------------------------------------------------------
// csi2tx_comp_byte_packer_pkg
// Shared constants for the compressed-code byte packer:
//   - compression scheme codes carried on comp_scheme[2:0]
//   - the three significant code widths (6/7/8 bits)
//   - packer state encoding
// ----------------------------------------------------------------------------
package csi2tx_comp_byte_packer_pkg;

  // Compression scheme selectors (comp_scheme[2:0]).
  localparam logic [2:0] C_10_8_10 = 3'd0;
  localparam logic [2:0] C_10_7_10 = 3'd1;
  localparam logic [2:0] C_10_6_10 = 3'd2;
  localparam logic [2:0] C_12_8_12 = 3'd3;
  localparam logic [2:0] C_12_7_12 = 3'd4;
  localparam logic [2:0] C_12_6_12 = 3'd5;

  // Significant bits per compressed code.
  localparam logic [3:0] CODE_W_6 = 4'd6;
  localparam logic [3:0] CODE_W_7 = 4'd7;
  localparam logic [3:0] CODE_W_8 = 4'd8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } pack_state_e;

endpackage

// File: rtl/csi2tx_code_width_dec.sv
// ----------------------------------------------------------------------------
// csi2tx_code_width_dec
// Combinational decode of the compression scheme into the number of
// significant bits per code. Unknown schemes decode to 8 bits.
// Ports:
//   scheme  in  3  comp_scheme[2:0]
//   w       out 4  code width (6, 7 or 8)
// ----------------------------------------------------------------------------
module csi2tx_code_width_dec
  import csi2tx_comp_byte_packer_pkg::*;
(
  input  logic [2:0] scheme,
  output logic [3:0] w
);

  always_comb begin
    w = CODE_W_8;
    case (scheme)
      C_10_6_10, C_12_6_12: w = CODE_W_6;
      C_10_7_10, C_12_7_12: w = CODE_W_7;
      default:              w = CODE_W_8;
    endcase
  end

endmodule

// File: rtl/csi2tx_comp_byte_packer.sv
// ----------------------------------------------------------------------------
// csi2tx_comp_byte_packer
// Packs 6/7/8-bit compressed codes MSB-first into a continuous byte stream
// (RAW6/RAW7/RAW8 packing). Every line starts byte-aligned; a line that ends
// with a partial byte pulses line_err.
//
// Build option: define CSI2TX_PACKER_PAD_EN to zero-pad a line-end residue
// into one extra byte (marked byte_last). Without it the residue is dropped.
//
// Ports:
//   clk           in   1  clock
//   reset         in   1  synchronous, active-high
//   comp_scheme   in   5  [2:0] selects code width, [4:3] unused here
//   enable        in   1  compression path enabled; low clears the packer
//   enc_data      in   8  right-justified code
//   enc_valid     in   1  code present
//   enc_line_end  in   1  last code of the line (qualified by enc_valid)
//   enc_ready     out  1  code accepted when enc_valid && enc_ready
//   byte_data     out  8  packed byte
//   byte_valid    out  1  byte present, held until byte_ready
//   byte_last     out  1  last byte of the line
//   byte_ready    in   1  downstream accepts
//   line_err      out  1  one-cycle pulse: line ended non-byte-aligned
// ----------------------------------------------------------------------------
module csi2tx_comp_byte_packer
  import csi2tx_comp_byte_packer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] comp_scheme,
  input  logic       enable,
  input  logic [7:0] enc_data,
  input  logic       enc_valid,
  input  logic       enc_line_end,
  output logic       enc_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_last,
  input  logic       byte_ready,
  output logic       line_err
);

  logic [15:0]  acc;          // valid bits left-aligned, oldest at acc[15]
  logic [3:0]   cnt;          // number of valid bits in acc
  pack_state_e  state;
  logic         line_active;  // a line has started (width latched)
  logic [3:0]   w_line;

  logic [3:0]   w_dec;
  logic [3:0]   w_cur;
  logic         slot_free;
  logic         load;
  logic         accept;
  logic         line_done;
  logic         ending;
  logic [3:0]   cnt_shift;
  logic [15:0]  acc_shift;
  logic [7:0]   code_mask;
  logic [7:0]   code_bits;
  logic [4:0]   code_sh;
  logic [15:0]  code_aligned;
  logic [15:0]  acc_app;
  logic [3:0]   cnt_app;
  logic         residue;
  logic         last_full;
  logic         set_last;
  logic         unused_scheme_hi;

  assign unused_scheme_hi = ^comp_scheme[4:3];

  csi2tx_code_width_dec u_width_dec (
    .scheme (comp_scheme[2:0]),
    .w      (w_dec)
  );

  // The first code of a line uses the live decode; later codes use the
  // width latched with that first code.
  assign w_cur     = line_active ? w_line : w_dec;

  assign slot_free = !byte_valid || byte_ready;
  assign load      = enable && (cnt >= 4'd8) && slot_free;
  assign enc_ready = !reset && enable && (state == ST_RUN) && ((cnt < 4'd8) || load);
  assign accept    = enc_valid && enc_ready;
  assign line_done = accept && enc_line_end;
  assign ending    = (state == ST_DRAIN) || line_done;

  // Shift out a loaded byte first, then append the new code below the
  // remaining valid bits.
  assign cnt_shift    = load ? (cnt - 4'd8) : cnt;
  assign acc_shift    = load ? {acc[7:0], 8'h00} : acc;
  assign code_mask    = 8'hFF >> (4'd8 - w_cur);
  assign code_bits    = enc_data & code_mask;
  assign code_sh      = 5'd16 - {1'b0, cnt_shift} - {1'b0, w_cur};
  assign code_aligned = {8'h00, code_bits} << code_sh;
  assign acc_app      = accept ? (acc_shift | code_aligned) : acc_shift;
  assign cnt_app      = accept ? (cnt_shift + w_cur) : cnt_shift;

  // Partial byte left over once the last full byte of a line has gone.
  assign residue   = (state == ST_DRAIN) && (cnt < 4'd8) && (cnt != 4'd0);

  // A load that leaves fewer than 8 bits of a finished line is the last
  // full byte of that line.
  assign last_full = load && ending && (cnt_app < 4'd8);

`ifdef CSI2TX_PACKER_PAD_EN
  logic pad_load;
  // With padding, the residue byte takes byte_last unless there is none.
  assign pad_load = enable && residue && slot_free;
  assign set_last = last_full && (cnt_app == 4'd0);
`else
  assign set_last = last_full;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      cnt         <= '0;
      state       <= ST_RUN;
      line_active <= 1'b0;
      w_line      <= CODE_W_8;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      byte_last   <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      line_err <= 1'b0;

      // Output byte register
`ifdef CSI2TX_PACKER_PAD_EN
      if (load) begin
        byte_data  <= acc[15:8];
        byte_valid <= 1'b1;
        byte_last  <= set_last;
      end else if (pad_load) begin
        // Bits below the residue are already zero in acc.
        byte_data  <= acc[15:8];
        byte_valid <= 1'b1;
        byte_last  <= 1'b1;
        line_err   <= 1'b1;
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
      end
`else
      if (load) begin
        byte_data  <= acc[15:8];
        byte_valid <= 1'b1;
        byte_last  <= set_last;
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
      end
`endif

      // Accumulator and line control
      if (!enable) begin
        acc         <= '0;
        cnt         <= '0;
        state       <= ST_RUN;
        line_active <= 1'b0;
      end else if (state == ST_RUN) begin
        acc <= acc_app;
        cnt <= cnt_app;
        if (accept) begin
          line_active <= 1'b1;
          if (!line_active) begin
            w_line <= w_dec;
          end
        end
        if (line_done) begin
          state <= ST_DRAIN;
        end
      end else begin
        if (cnt >= 4'd8) begin
          acc <= acc_app;
          cnt <= cnt_app;
        end else if (!residue) begin
          state       <= ST_RUN;
          line_active <= 1'b0;
        end else begin
`ifdef CSI2TX_PACKER_PAD_EN
          if (slot_free) begin
            acc         <= '0;
            cnt         <= '0;
            state       <= ST_RUN;
            line_active <= 1'b0;
          end
`else
          acc         <= '0;
          cnt         <= '0;
          state       <= ST_RUN;
          line_active <= 1'b0;
          line_err    <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_csi2tx_comp_byte_packer.sv
module tb_csi2tx_comp_byte_packer;
  import csi2tx_comp_byte_packer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] comp_scheme;
  logic       enable;
  logic [7:0] enc_data;
  logic       enc_valid;
  logic       enc_line_end;
  logic       enc_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       line_err;

  always #5 clk = ~clk;

  csi2tx_comp_byte_packer dut (
    .clk          (clk),
    .reset        (reset),
    .comp_scheme  (comp_scheme),
    .enable       (enable),
    .enc_data     (enc_data),
    .enc_valid    (enc_valid),
    .enc_line_end (enc_line_end),
    .enc_ready    (enc_ready),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_last    (byte_last),
    .byte_ready   (byte_ready),
    .line_err     (line_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Everything transferred on the byte side, as {last, data}.
  logic [8:0] got_q[$];
  int         err_seen = 0;

  always @(negedge clk) begin
    if (byte_valid && byte_ready) got_q.push_back({byte_last, byte_data});
    if (line_err) err_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int width_of(input logic [2:0] s);
    case (s)
      C_10_6_10, C_12_6_12: return 6;
      C_10_7_10, C_12_7_12: return 7;
      default:              return 8;
    endcase
  endfunction

  // Reference: lay all code bits out as one bit stream, cut into bytes.
  task automatic model(input logic [4:0] sch, input logic [7:0] codes[$],
                       output logic [8:0] exp_q[$], output int exp_err);
    bit         bq[$];
    int         w;
    int         nfull;
    int         r;
    logic [7:0] v;
    w = width_of(sch[2:0]);
    foreach (codes[i])
      for (int b = w - 1; b >= 0; b--) bq.push_back(codes[i][b]);
    nfull = bq.size() / 8;
    r     = bq.size() % 8;
    exp_q = {};
    for (int k = 0; k < nfull; k++) begin
      for (int j = 0; j < 8; j++) v[7-j] = bq[8*k+j];
      exp_q.push_back({1'b0, v});
    end
`ifdef CSI2TX_PACKER_PAD_EN
    if (r != 0) begin
      v = 8'h00;
      for (int j = 0; j < r; j++) v[7-j] = bq[8*nfull+j];
      exp_q.push_back({1'b0, v});
    end
`endif
    if (exp_q.size() > 0) exp_q[exp_q.size()-1][8] = 1'b1;
    exp_err = (r != 0) ? 1 : 0;
  endtask

  // rmode 0: byte_ready=1; 1: random; 2: 10-cycle stall from cycle 3.
  task automatic run_line(input logic [4:0] sch, input logic [7:0] codes[$],
                          input int rmode, output int cycles);
    int         idx;
    int         cyc;
    logic [7:0] stall_data;
    idx = 0;
    cyc = 0;
    stall_data = 8'h00;
    comp_scheme = sch;
    while (idx < codes.size() && cyc < 400) begin
      case (rmode)
        1:       byte_ready = 1'($urandom_range(0, 1));
        2:       byte_ready = !(cyc >= 3 && cyc < 13);
        default: byte_ready = 1'b1;
      endcase
      enc_valid    = 1'b1;
      enc_data     = codes[idx];
      enc_line_end = (idx == codes.size() - 1);
      @(negedge clk);
      if (rmode == 2 && cyc == 3) stall_data = byte_data;
      if (rmode == 2 && cyc > 3 && cyc < 13) check("stall_byte_data", byte_data, stall_data);
      if (rmode == 2 && cyc == 12) begin
        check("stall_enc_ready", enc_ready, 0);
        check("stall_byte_valid", byte_valid, 1);
      end
      if (enc_ready) idx++;
      tick();
      cyc++;
    end
    enc_valid    = 1'b0;
    enc_line_end = 1'b0;
    if (idx < codes.size()) check("accept_timeout", idx, codes.size());
    cycles = cyc;
    byte_ready = 1'b1;
    repeat (30) tick();
  endtask

  task automatic check_line(input string name, input logic [8:0] exp_q[$], input int exp_err,
                            input int base, input int ebase);
    int n;
    n = got_q.size() - base;
    check({name, "_nbytes"}, n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < n; k++)
      check($sformatf("%s_byte%0d", name, k), got_q[base+k], exp_q[k]);
    check({name, "_line_err"}, err_seen - ebase, exp_err);
  endtask

  typedef struct {
    logic [4:0]  sch;
    int          n;
    logic [63:0] codes;   // first code in the top byte
    int          nexp;
    logic [63:0] exp;     // first byte in the top byte; last flag on final
    int          err;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] cq[$];
    logic [8:0] eq[$];
    int         eerr;
    int         base;
    int         ebase;
    int         cyc;

    vt[0] = '{{2'b00, C_10_6_10}, 4, 64'h3F00152A_00000000, 3, 64'hFC056A00_00000000, 0};
    vt[1] = '{{2'b00, C_10_7_10}, 8, 64'h7F7F7F7F_7F7F7F7F, 7, 64'hFFFFFFFF_FFFFFF00, 0};
    vt[2] = '{{2'b00, C_10_8_10}, 2, 64'hA53C0000_00000000, 2, 64'hA53C0000_00000000, 0};
`ifdef CSI2TX_PACKER_PAD_EN
    vt[3] = '{{2'b00, C_12_6_12}, 3, 64'h3F3F3F00_00000000, 3, 64'hFFFFC000_00000000, 1};
    vt[4] = '{{2'b00, C_10_6_10}, 1, 64'h2A000000_00000000, 1, 64'hA8000000_00000000, 1};
`else
    vt[3] = '{{2'b00, C_12_6_12}, 3, 64'h3F3F3F00_00000000, 2, 64'hFFFF0000_00000000, 1};
    vt[4] = '{{2'b00, C_10_6_10}, 1, 64'h2A000000_00000000, 0, 64'h00000000_00000000, 1};
`endif
    vt[5] = '{{2'b11, C_12_6_12}, 4, 64'hFFFFFFFF_00000000, 3, 64'hFFFFFF00_00000000, 0};

    reset        = 1'b1;
    enable       = 1'b1;
    comp_scheme  = 5'd0;
    enc_data     = 8'h00;
    enc_valid    = 1'b0;
    enc_line_end = 1'b0;
    byte_ready   = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_enc_ready", enc_ready, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_last", byte_last, 0);
    check("rst_line_err", line_err, 0);
    tick();
    reset = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      cq = {};
      eq = {};
      for (int k = 0; k < vt[i].n; k++) cq.push_back(vt[i].codes[63-8*k -: 8]);
      for (int k = 0; k < vt[i].nexp; k++)
        eq.push_back({(k == vt[i].nexp - 1), vt[i].exp[63-8*k -: 8]});
      base  = got_q.size();
      ebase = err_seen;
      run_line(vt[i].sch, cq, 0, cyc);
      check_line($sformatf("vec%0d", i), eq, vt[i].err, base, ebase);
      if (i == 1) check("tput_7bit_cycles", cyc, 8);
    end

    // Latency: 8-bit code accepted on edge N -> byte_valid after edge N+1
    base  = got_q.size();
    ebase = err_seen;
    comp_scheme  = {2'b00, C_12_8_12};
    enc_valid    = 1'b1;
    enc_data     = 8'hA5;
    enc_line_end = 1'b0;
    @(negedge clk);
    check("lat_enc_ready", enc_ready, 1);
    tick();
    enc_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_n", byte_valid, 0);
    tick();
    @(negedge clk);
    check("lat_valid_n1", byte_valid, 1);
    check("lat_data_n1", byte_data, 8'hA5);
    tick();
    cq = {8'h3C};
    run_line({2'b00, C_12_8_12}, cq, 0, cyc);
    eq = {9'h0A5, 9'h13C};
    check_line("latency", eq, 0, base, ebase);

    // Backpressure stall mid-stream: same bytes as the unstalled run
    cq = {8'h3F, 8'h00, 8'h15, 8'h2A, 8'h11, 8'h22, 8'h33, 8'h3C};
    model({2'b00, C_10_6_10}, cq, eq, eerr);
    base  = got_q.size();
    ebase = err_seen;
    run_line({2'b00, C_10_6_10}, cq, 2, cyc);
    check_line("stall", eq, eerr, base, ebase);

    // Reset mid-line with cnt=5 (three 7-bit codes, two bytes loaded)
    comp_scheme = {2'b00, C_10_7_10};
    enc_valid   = 1'b1;
    enc_data    = 8'h55;
    repeat (3) tick();
    enc_valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_enc_ready", enc_ready, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_byte_valid", byte_valid, 0);
    check("mid_rst_byte_data", byte_data, 0);
    check("mid_rst_byte_last", byte_last, 0);
    check("mid_rst_line_err", line_err, 0);
    tick();
    base  = got_q.size();
    ebase = err_seen;
    cq = {8'h2A, 8'h15, 8'h3F, 8'h00};
    run_line({2'b00, C_10_6_10}, cq, 0, cyc);
    eq = {9'h0A9, 9'h05F, 9'h1C0};
    check_line("after_rst", eq, 0, base, ebase);

    // enable low mid-line clears the partial line
    base  = got_q.size();
    ebase = err_seen;
    comp_scheme = {2'b00, C_10_6_10};
    enc_valid   = 1'b1;
    enc_data    = 8'h3F;
    tick();
    enc_valid = 1'b0;
    enable    = 1'b0;
    @(negedge clk);
    check("dis_enc_ready", enc_ready, 0);
    repeat (2) tick();
    enable = 1'b1;
    cq = {8'h5A};
    run_line({2'b00, C_10_8_10}, cq, 0, cyc);
    eq = {9'h15A};
    check_line("after_disable", eq, 0, base, ebase);

    // Randomized lines against the reference model
    for (int r = 0; r < 25; r++) begin
      logic [4:0] sch;
      int         n;
      sch = 5'($urandom_range(0, 31));
      n   = $urandom_range(1, 12);
      cq  = {};
      for (int k = 0; k < n; k++) cq.push_back(8'($urandom));
      model(sch, cq, eq, eerr);
      base  = got_q.size();
      ebase = err_seen;
      run_line(sch, cq, $urandom_range(0, 1), cyc);
      check_line($sformatf("rand%0d", r), eq, eerr, base, ebase);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
